// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage.
// Holds the datapath and register-number widths, the opcode encodings,
// the FSM state encoding and the flag payload struct.
package ex_pkg;

  localparam int unsigned DW      = 16;               // datapath width
  localparam int unsigned RW      = 3;                // register-number width
  localparam int unsigned OPW     = 4;                // opcode width
  localparam int unsigned MUL_CYC = 16;               // multiply iterations, equals DW
  localparam int unsigned PW      = 2 * DW;           // full product width
  localparam int unsigned CNT_W   = $clog2(MUL_CYC);  // iteration counter width
  localparam int unsigned SHW     = $clog2(DW);       // shift-amount width

  localparam logic [OPW-1:0] OP_MOV = 4'd0;
  localparam logic [OPW-1:0] OP_ADD = 4'd1;
  localparam logic [OPW-1:0] OP_SUB = 4'd2;
  localparam logic [OPW-1:0] OP_AND = 4'd3;
  localparam logic [OPW-1:0] OP_OR  = 4'd4;
  localparam logic [OPW-1:0] OP_XOR = 4'd5;
  localparam logic [OPW-1:0] OP_NOT = 4'd6;
  localparam logic [OPW-1:0] OP_SLL = 4'd7;
  localparam logic [OPW-1:0] OP_SRL = 4'd8;
  localparam logic [OPW-1:0] OP_SRA = 4'd9;
  localparam logic [OPW-1:0] OP_MUL = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Flag payload travelling with each result to write-back.
  typedef struct packed {
    logic z;
    logic c;
    logic n;
  } flags_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : load operands a/b and begin a multiply
//   a, b       : multiplicand and multiplier
//   busy       : a multiply is in progress (registered)
//   done       : current edge performs the final iteration
//   product    : accumulator value after the current iteration
// done and product are combinational so the owner can capture the final
// product on the same edge that the last iteration happens.
module mul_seq
  import ex_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product
);

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [DW-1:0]    mplr;
  logic [CNT_W-1:0] cnt;

  // Accumulator after adding this iteration's partial product.
  assign product = acc + (mplr[0] ? mcand : '0);
  assign done    = busy && (cnt == CNT_W'(MUL_CYC - 1));

  // Operand load and per-iteration shift/accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= {{(PW - DW){1'b0}}, a};
      mplr  <= b;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= product;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 16-cycle sequential multiply.
// Ports:
//   clk_ex, rst_n      : stage clock, synchronous active-low reset
//   valid_in/ready_out : input handshake; ready_out is high only in IDLE
//   op_in, n_reg_in    : opcode and destination register number
//   a_in, b_in         : operands
//   valid_out          : one-cycle result-valid pulse
//   n_reg_out          : destination register of the result
//   result_out         : result value
//   flag_z/c/n         : zero, carry/borrow/overflow, negative flags
// All outputs except ready_out are registered and hold between results.
module ex_stage
  import ex_pkg::*;
(
  input  logic           clk_ex,
  input  logic           rst_n,
  input  logic           valid_in,
  output logic           ready_out,
  input  logic [OPW-1:0] op_in,
  input  logic [RW-1:0]  n_reg_in,
  input  logic [DW-1:0]  a_in,
  input  logic [DW-1:0]  b_in,
  output logic           valid_out,
  output logic [RW-1:0]  n_reg_out,
  output logic [DW-1:0]  result_out,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_n
);

  state_t        state;
  state_t        state_d;
  logic          accept;

  logic [DW:0]   alu_wide;
  logic          alu_legal;

  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [PW-1:0] mul_product;

  logic [RW-1:0] n_reg_lat;
  logic [RW-1:0] n_reg_lat_d;

  logic          valid_d;
  logic [RW-1:0] n_reg_d;
  logic [DW-1:0] result_d;
  flags_t        flags_q;
  flags_t        flags_d;

  mul_seq u_mul (
    .clk     (clk_ex),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a_in),
    .b       (b_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign ready_out = (state == ST_IDLE) && !mul_busy;
  assign accept    = valid_in && ready_out;

  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_n = flags_q.n;

  // Single-cycle ALU; bit DW carries ADD carry-out / SUB borrow.
  always_comb begin
    alu_wide  = '0;
    alu_legal = 1'b1;
    case (op_in)
      OP_MOV:  alu_wide = {1'b0, b_in};
      OP_ADD:  alu_wide = {1'b0, a_in} + {1'b0, b_in};
      OP_SUB:  alu_wide = {1'b0, a_in} - {1'b0, b_in};
      OP_AND:  alu_wide = {1'b0, a_in & b_in};
      OP_OR:   alu_wide = {1'b0, a_in | b_in};
      OP_XOR:  alu_wide = {1'b0, a_in ^ b_in};
      OP_NOT:  alu_wide = {1'b0, ~a_in};
      OP_SLL:  alu_wide = {1'b0, a_in << b_in[SHW-1:0]};
      OP_SRL:  alu_wide = {1'b0, a_in >> b_in[SHW-1:0]};
      OP_SRA:  alu_wide = {1'b0, DW'($signed(a_in) >>> b_in[SHW-1:0])};
      default: alu_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    mul_start   = 1'b0;
    n_reg_lat_d = n_reg_lat;
    valid_d     = 1'b0;
    n_reg_d     = n_reg_out;
    result_d    = result_out;
    flags_d     = flags_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_in == OP_MUL) begin
            mul_start   = 1'b1;
            n_reg_lat_d = n_reg_in;
            state_d     = ST_MUL;
          end else begin
            valid_d = 1'b1;
            n_reg_d = n_reg_in;
            if (alu_legal) begin
              result_d  = alu_wide[DW-1:0];
              flags_d.z = (alu_wide[DW-1:0] == '0);
              flags_d.c = alu_wide[DW];
              flags_d.n = alu_wide[DW-1];
            end else begin
              // Illegal opcode: zero result, flags untouched.
              result_d = '0;
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          valid_d   = 1'b1;
          n_reg_d   = n_reg_lat;
          result_d  = mul_product[DW-1:0];
          flags_d.z = (mul_product[DW-1:0] == '0);
          flags_d.c = |mul_product[PW-1:DW];
          flags_d.n = mul_product[DW-1];
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_ex) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n_reg_lat  <= '0;
      valid_out  <= 1'b0;
      n_reg_out  <= '0;
      result_out <= '0;
      flags_q    <= '0;
    end else begin
      state      <= state_d;
      n_reg_lat  <= n_reg_lat_d;
      valid_out  <= valid_d;
      n_reg_out  <= n_reg_d;
      result_out <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clk_ex = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  op_in;
  logic [2:0]  n_reg_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        valid_out;
  logic [2:0]  n_reg_out;
  logic [15:0] result_out;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  ex_stage dut (
    .clk_ex     (clk_ex),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op_in      (op_in),
    .n_reg_in   (n_reg_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .valid_out  (valid_out),
    .n_reg_out  (n_reg_out),
    .result_out (result_out),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_n     (flag_n)
  );

  always #5 clk_ex = ~clk_ex;

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_ex);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] n);
    valid_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    n_reg_in = n;
  endtask

  // Issue one single-cycle op and check the registered result; valid_in stays high.
  task automatic alu_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] n, input logic [15:0] res,
                        input logic [2:0] zcn);
    drive(op, a, b, n);
    tick();
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_res"},   32'(result_out), 32'(res));
    check({tag, "_zcn"},   32'({flag_z, flag_c, flag_n}), 32'(zcn));
    check({tag, "_nreg"},  32'(n_reg_out), 32'(n));
  endtask

  // Issue a MUL and follow it through its 16-cycle latency.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] n, input logic [15:0] res, input logic c);
    drive(4'd10, a, b, n);
    tick();
    valid_in = 1'b0;
    check({tag, "_accept_vr"}, 32'({valid_out, ready_out}), 32'b00);
    for (int i = 1; i < 16; i++) begin
      tick();
      check({tag, "_busy_vr"}, 32'({valid_out, ready_out}), 32'b00);
    end
    tick();
    check({tag, "_done_vr"}, 32'({valid_out, ready_out}), 32'b11);
    check({tag, "_res"},  32'(result_out), 32'(res));
    check({tag, "_zcn"},  32'({flag_z, flag_c, flag_n}), 32'({res == 16'h0, c, res[15]}));
    check({tag, "_nreg"}, 32'(n_reg_out), 32'(n));
    tick();
    check({tag, "_pulse_end"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    op_in    = '0;
    n_reg_in = '0;
    a_in     = '0;
    b_in     = '0;
    tick();
    tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_res",   32'(result_out), 32'd0);
    check("rst_nreg",  32'(n_reg_out), 32'd0);
    check("rst_zcn",   32'({flag_z, flag_c, flag_n}), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    rst_n = 1'b1;
    tick();

    // ADD wrap to zero, then outputs hold with valid_out low.
    alu_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 3'd5, 16'h0000, 3'b110);
    check("add_ready", 32'(ready_out), 32'd1);
    valid_in = 1'b0;
    tick();
    check("add_pulse_end", 32'(valid_out), 32'd0);
    check("add_hold_res",  32'(result_out), 32'd0);
    check("add_hold_zcn",  32'({flag_z, flag_c, flag_n}), 32'b110);

    // Back-to-back SUB with borrow, then SRA.
    alu_op("sub_borrow", 4'd2, 16'd3, 16'd5, 3'd1, 16'hFFFE, 3'b011);
    alu_op("sra_15", 4'd9, 16'h8000, 16'd15, 3'd4, 16'hFFFF, 3'b001);
    alu_op("sll_hi_ign", 4'd7, 16'h0001, 16'h0013, 3'd2, 16'h0008, 3'b000);
    alu_op("srl", 4'd8, 16'h8000, 16'd4, 3'd3, 16'h0800, 3'b000);
    alu_op("mov_zero", 4'd0, 16'h1234, 16'h0000, 3'd6, 16'h0000, 3'b100);
    alu_op("not", 4'd6, 16'h00FF, 16'h0000, 3'd7, 16'hFF00, 3'b001);
    alu_op("xor", 4'd5, 16'hF0F0, 16'hFF00, 3'd0, 16'h0FF0, 3'b000);
    valid_in = 1'b0;
    tick();

    // Multiplies.
    run_mul("mul_300", 16'd300, 16'd300, 3'd2, 16'h5F90, 1'b1);
    run_mul("mul_7x9", 16'd7, 16'd9, 3'd3, 16'h003F, 1'b0);

    // ADD held on valid_in during a MUL is taken exactly once, after it.
    drive(4'd10, 16'd4, 16'd5, 3'd6);
    tick();
    drive(4'd1, 16'd10, 16'd20, 3'd7);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("hold_busy_vr", 32'({valid_out, ready_out}), 32'b00);
    end
    tick();
    check("hold_mul_valid", 32'(valid_out), 32'd1);
    check("hold_mul_res",   32'(result_out), 32'h14);
    check("hold_mul_nreg",  32'(n_reg_out), 32'd6);
    check("hold_ready",     32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    check("hold_add_valid", 32'(valid_out), 32'd1);
    check("hold_add_res",   32'(result_out), 32'h1E);
    check("hold_add_nreg",  32'(n_reg_out), 32'd7);
    tick();
    check("hold_add_once",  32'(valid_out), 32'd0);

    // Reset in the middle of a MUL discards it.
    drive(4'd10, 16'd100, 16'd100, 3'd1);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_valid", 32'(valid_out), 32'd0);
    check("mrst_res",   32'(result_out), 32'd0);
    check("mrst_nreg",  32'(n_reg_out), 32'd0);
    check("mrst_zcn",   32'({flag_z, flag_c, flag_n}), 32'd0);
    check("mrst_ready", 32'(ready_out), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_no_valid", 32'(valid_out), 32'd0);
    end
    run_mul("mul_2x3", 16'd2, 16'd3, 3'd5, 16'h0006, 1'b0);

    // Illegal opcode keeps the flags from the previous ADD.
    alu_op("pre_ill_add", 4'd1, 16'hFFFF, 16'h0001, 3'd3, 16'h0000, 3'b110);
    drive(4'd12, 16'd5, 16'd6, 3'd4);
    tick();
    valid_in = 1'b0;
    check("ill_valid", 32'(valid_out), 32'd1);
    check("ill_res",   32'(result_out), 32'd0);
    check("ill_zcn",   32'({flag_z, flag_c, flag_n}), 32'b110);
    tick();
    check("ill_pulse_end", 32'(valid_out), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit, 8-register CPU. Sits directly downstream of the register-read/decode stage.
- Consumes the selected register value and its destination register number, plus a second operand and an opcode.
- Performs the ALU operation and registers the result, destination number and flags for write-back.
- Single-cycle ops complete in 1 cycle. MUL is a 16-cycle sequential shift-add, with back-pressure via ready_out.

Parameters:
- DW, 16, datapath width.
- RW, 3, register-number width (8 registers).
- MUL_CYC, 16, multiply iterations; must equal DW.

Ports:
- clk_ex  in  1  stage clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  operand/op bundle valid.
- ready_out  out  1  stage can accept; high only in IDLE (combinational from state).
- op_in  in  4  opcode.
- n_reg_in  in  3  destination register number.
- a_in  in  16  operand A (register value from decode).
- b_in  in  16  operand B (register or immediate).
- valid_out  out  1  one-cycle pulse: result valid.
- n_reg_out  out  3  destination register number of the result.
- result_out  out  16  result.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow/overflow flag.
- flag_n  out  1  negative flag (result[15]).

Behaviour:
- Reset: when rst_n=0 at posedge, the following are forced to 0: state=IDLE, valid_out, n_reg_out, result_out, flags, multiplier registers. Reset overrides everything, including an in-flight MUL; the MUL is discarded with no valid_out.
- Accept condition: valid_in & ready_out at posedge. valid_in while ready_out=0 is ignored; upstream must hold the bundle.
- Opcodes (single-cycle unless noted):
  - 0 MOV: result = b.
  - 1 ADD: a+b, C = bit16.
  - 2 SUB: a-b, C = borrow (a<b unsigned).
  - 3 AND, 4 OR, 5 XOR, 6 NOT a.
  - 7 SLL: a << b[3:0]. 8 SRL: logical right. 9 SRA: arithmetic right.
  - 10 MUL: multi-cycle, see below.
  - 11-15 illegal: result = 0, valid_out pulses, flags unchanged.
- Flags: Z = (result==0) and N = result[15] for all legal ops. C = 0 for ops other than ADD/SUB/MUL.
- Single-cycle latency: accepted at edge k -> result/flags/n_reg_out registered at edge k, valid_out=1 for exactly one cycle. Back-to-back accepts every cycle are allowed.
- FSM states: IDLE, MUL.
  - IDLE + accept MUL: load mcand = {16'b0, a}, mplr = b, acc = 0, cnt = 0, latch n_reg; -> MUL. valid_out = 0 at this edge.
  - MUL, each edge: if mplr[0], acc += mcand; mcand <<= 1; mplr >>= 1; cnt++.
  - On the edge where cnt==15: result_out = acc_next[15:0], C = |acc_next[31:16], Z/N from result_out, valid_out=1, n_reg_out = latched n_reg; -> IDLE.
- MUL timing: accepted at edge k, result at edge k+16. ready_out is low for cycles k+1..k+16 and high again in the cycle valid_out is shown, so a new accept is possible on that cycle.
- Outputs hold their last value while valid_out=0.
- Arithmetic wraps modulo 2^16. Shift amount uses b[3:0] only; b[15:4] is ignored.

Decomposition:
- Package ex_pkg: opcode localparams (OP_MOV..OP_MUL), DW/RW constants, state encoding.
- One sub-module, mul_seq: the shift-add multiplier. Ports: start, a, b, busy, done, product[31:0]. ex_stage owns the FSM, ALU and output registers.

Test Plan:
- ADD a=0xFFFF, b=0x0001, n_reg=5 -> next cycle: result 0x0000, Z=1, C=1, N=0, n_reg_out=5, valid_out pulse 1 cycle.
- SUB a=3, b=5 -> 0xFFFE, C=1, N=1, Z=0. Then SRA a=0x8000, b=15 on the following cycle (back-to-back) -> 0xFFFF, C=0, N=1.
- MUL a=300, b=300, n_reg=2 -> ready_out=0 for 16 cycles; valid_out 16 cycles after accept with result 0x5F90, C=1, n_reg_out=2. Repeat with 7*9 -> 63, C=0.
- valid_in held high with ADD during a MUL -> ignored until ready_out=1, then accepted once. Exactly one valid_out each for the MUL and the ADD, in order.
- rst_n=0 for one cycle at iteration 8 of a MUL -> all outputs 0, ready_out=1, no valid_out. A subsequent MUL 2*3 -> 6.
- Illegal op 12 after ADD set Z=1 -> result 0x0000, valid_out pulse, flags keep Z=1, C=1.
